// File: rtl/mult_pipe_model.sv
// Cycle-accurate model of a DSP multiplier slice with optional input, pipeline and
// output register stages, a B/C operand select and a valid tag that follows the data.
module mult_pipe_model #(
    parameter int A_WIDTH         = 18,
    parameter int B_WIDTH         = 18,
    parameter int REG_INPUT       = 1,
    parameter int REG_PIPELINE    = 1,
    parameter int REG_OUTPUT      = 1,
    parameter int SOURCEB_DYNAMIC = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CEN,
    input  logic                       VALID_IN,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         C,
    input  logic                       SOURCEB,
    input  logic                       SIGNEDA,
    input  logic                       SIGNEDB,
    output logic [A_WIDTH+B_WIDTH-1:0] P,
    output logic                       SIGNEDP,
    output logic                       VALID_OUT
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [B_WIDTH-1:0] w_bsel;
    logic [A_WIDTH-1:0] w_s1_a;
    logic [B_WIDTH-1:0] w_s1_b;
    logic               w_s1_sa;
    logic               w_s1_sb;
    logic               w_s1_v;
    logic [P_WIDTH-1:0] w_a_ext;
    logic [P_WIDTH-1:0] w_b_ext;
    logic [P_WIDTH-1:0] w_prod;
    logic               w_sp;
    logic [P_WIDTH-1:0] w_s2_p;
    logic               w_s2_sp;
    logic               w_s2_v;

    assign w_bsel = ((SOURCEB_DYNAMIC != 0) && SOURCEB) ? C : B;

    generate
        if (REG_INPUT != 0) begin : g_in_reg
            logic [A_WIDTH-1:0] r_a;
            logic [B_WIDTH-1:0] r_b;
            logic               r_sa;
            logic               r_sb;
            logic               r_v;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_sa <= 1'b0;
                    r_sb <= 1'b0;
                    r_v  <= 1'b0;
                end else if (CEN) begin
                    r_a  <= A;
                    r_b  <= w_bsel;
                    r_sa <= SIGNEDA;
                    r_sb <= SIGNEDB;
                    r_v  <= VALID_IN;
                end
            end
            assign w_s1_a  = r_a;
            assign w_s1_b  = r_b;
            assign w_s1_sa = r_sa;
            assign w_s1_sb = r_sb;
            assign w_s1_v  = r_v;
        end else begin : g_in_wire
            assign w_s1_a  = A;
            assign w_s1_b  = w_bsel;
            assign w_s1_sa = SIGNEDA;
            assign w_s1_sb = SIGNEDB;
            assign w_s1_v  = VALID_IN;
        end
    endgenerate

    // Extending both operands to the full product width makes a plain modular
    // multiply exact for every signedness combination.
    assign w_a_ext = {{B_WIDTH{w_s1_sa & w_s1_a[A_WIDTH-1]}}, w_s1_a};
    assign w_b_ext = {{A_WIDTH{w_s1_sb & w_s1_b[B_WIDTH-1]}}, w_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_sp    = w_s1_sa | w_s1_sb;

    generate
        if (REG_PIPELINE != 0) begin : g_pipe_reg
            logic [P_WIDTH-1:0] r_p;
            logic               r_sp;
            logic               r_v;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_p  <= '0;
                    r_sp <= 1'b0;
                    r_v  <= 1'b0;
                end else if (CEN) begin
                    r_p  <= w_prod;
                    r_sp <= w_sp;
                    r_v  <= w_s1_v;
                end
            end
            assign w_s2_p  = r_p;
            assign w_s2_sp = r_sp;
            assign w_s2_v  = r_v;
        end else begin : g_pipe_wire
            assign w_s2_p  = w_prod;
            assign w_s2_sp = w_sp;
            assign w_s2_v  = w_s1_v;
        end
    endgenerate

    generate
        if (REG_OUTPUT != 0) begin : g_out_reg
            logic [P_WIDTH-1:0] r_p;
            logic               r_sp;
            logic               r_v;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    r_p  <= '0;
                    r_sp <= 1'b0;
                    r_v  <= 1'b0;
                end else if (CEN) begin
                    r_p  <= w_s2_p;
                    r_sp <= w_s2_sp;
                    r_v  <= w_s2_v;
                end
            end
            assign P         = r_p;
            assign SIGNEDP   = r_sp;
            assign VALID_OUT = r_v;
        end else begin : g_out_wire
            assign P         = w_s2_p;
            assign SIGNEDP   = w_s2_sp;
            assign VALID_OUT = w_s2_v;
        end
    endgenerate
endmodule

// File: tb/tb_mult_pipe_model.sv
// Drives all eight register configurations plus a static-source instance with
// shared stimulus and compares every output against a sample-history reference.
module tb_mult_pipe_model;
    localparam int N_DUT = 9;

    typedef struct packed {
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] c;
        logic        src;
        logic        sa;
        logic        sb;
        logic        v;
    } sample_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CEN = 1'b1;
    logic        VALID_IN = 1'b0;
    logic [17:0] A = '0;
    logic [17:0] B = '0;
    logic [17:0] C = '0;
    logic        SOURCEB = 1'b0;
    logic        SIGNEDA = 1'b0;
    logic        SIGNEDB = 1'b0;

    logic [35:0] p_out  [N_DUT];
    logic        sp_out [N_DUT];
    logic        v_out  [N_DUT];

    int n_checks = 0;
    int n_pass   = 0;
    sample_t hist[$];

    always #5 CLK = ~CLK;

    // Index gi encodes {REG_INPUT, REG_PIPELINE, REG_OUTPUT}; index 8 is the
    // fully registered slice with a static B source.
    genvar gi;
    generate
        for (gi = 0; gi < N_DUT; gi++) begin : g_dut
            mult_pipe_model #(
                .A_WIDTH(18), .B_WIDTH(18),
                .REG_INPUT   ((gi == 8) ? 1 : ((gi >> 2) & 1)),
                .REG_PIPELINE((gi == 8) ? 1 : ((gi >> 1) & 1)),
                .REG_OUTPUT  ((gi == 8) ? 1 : (gi & 1)),
                .SOURCEB_DYNAMIC((gi == 8) ? 0 : 1)
            ) u_dut (
                .CLK(CLK), .RESET(RESET), .CEN(CEN), .VALID_IN(VALID_IN),
                .A(A), .B(B), .C(C), .SOURCEB(SOURCEB),
                .SIGNEDA(SIGNEDA), .SIGNEDB(SIGNEDB),
                .P(p_out[gi]), .SIGNEDP(sp_out[gi]), .VALID_OUT(v_out[gi])
            );
        end
    endgenerate

    function automatic sample_t cur_sample();
        sample_t s;
        s.a = A; s.b = B; s.c = C; s.src = SOURCEB;
        s.sa = SIGNEDA; s.sb = SIGNEDB; s.v = VALID_IN;
        return s;
    endfunction

    // Reference: every enabled edge outside reset captures one sample; an output
    // with latency L shows the sample captured L enabled edges ago.
    always @(posedge CLK) begin
        if (!RESET && CEN) begin
            hist.push_front(cur_sample());
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    always @(posedge RESET) hist.delete();

    function automatic logic [35:0] ref_product(sample_t s, bit dyn);
        logic [17:0] bsel;
        longint av, bv, prod;
        bsel = (dyn && s.src) ? s.c : s.b;
        av = s.sa ? longint'($signed(s.a)) : longint'(s.a);
        bv = s.sb ? longint'($signed(bsel)) : longint'(bsel);
        prod = av * bv;
        return prod[35:0];
    endfunction

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic compare_all();
        for (int k = 0; k < N_DUT; k++) begin
            int lat;
            sample_t s;
            logic [35:0] ep;
            logic esp, ev;
            lat = (k == 8) ? 3 : (((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1));
            if (lat == 0) begin
                s = cur_sample();
                ep = ref_product(s, 1'b1); esp = s.sa | s.sb; ev = s.v;
            end else if (hist.size() < lat) begin
                ep = '0; esp = 1'b0; ev = 1'b0;
            end else begin
                s = hist[lat-1];
                ep = ref_product(s, k != 8); esp = s.sa | s.sb; ev = s.v;
            end
            check_value($sformatf("cfg%0d_P", k), 64'(p_out[k]), 64'(ep));
            check_value($sformatf("cfg%0d_SIGNEDP", k), 64'(sp_out[k]), 64'(esp));
            check_value($sformatf("cfg%0d_VALID", k), 64'(v_out[k]), 64'(ev));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic apply(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c,
                         input logic src, input logic sa, input logic sb, input logic v);
        A = a; B = b; C = c; SOURCEB = src; SIGNEDA = sa; SIGNEDB = sb; VALID_IN = v;
    endtask

    initial begin
        logic [35:0] frozen_p;
        logic        frozen_v;

        #1 RESET = 1'b1;
        @(negedge CLK);
        compare_all();
        check_value("reset_P", 64'(p_out[7]), 64'd0);
        check_value("reset_VALID", 64'(v_out[7]), 64'd0);
        RESET = 1'b0;
        tick();

        // Unsigned full-scale, plus same-cycle result on the all-bypass slice
        apply(18'h3FFFF, 18'h3FFFF, 18'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 check_value("comb_P", 64'(p_out[0]), 64'hFFFF80001);
        tick();
        apply(18'h0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_value("unsigned_early_VALID", 64'(v_out[7]), 64'd0);
        tick();
        check_value("unsigned_P", 64'(p_out[7]), 64'hFFFF80001);
        check_value("unsigned_SIGNEDP", 64'(sp_out[7]), 64'd0);
        check_value("unsigned_VALID", 64'(v_out[7]), 64'd1);
        tick();
        check_value("unsigned_VALID_drop", 64'(v_out[7]), 64'd0);

        // Signed and mixed signedness
        apply(18'h3FFFF, 18'd2, 18'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        apply(18'h3FFFF, 18'h3FFFF, 18'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        apply(18'h0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_value("signed_P", 64'(p_out[7]), 64'hFFFFFFFFE);
        check_value("signed_SIGNEDP", 64'(sp_out[7]), 64'd1);
        tick();
        check_value("mixed_P", 64'(p_out[7]), 64'hFFFFC0001);

        // Source select, dynamic and static
        apply(18'd7, 18'd3, 18'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        apply(18'd7, 18'd3, 18'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_value("srcC_P", 64'(p_out[7]), 64'd35);
        check_value("static_src_P", 64'(p_out[8]), 64'd21);
        tick();
        check_value("srcB_P", 64'(p_out[7]), 64'd21);

        // Clock-enable stall in the middle of a stream
        for (int i = 1; i <= 4; i++) begin
            apply(18'(i), 18'd1, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 3) begin
                CEN = 1'b0;
                frozen_p = p_out[7];
                frozen_v = v_out[7];
                for (int j = 0; j < 2; j++) begin
                    tick();
                    check_value("stall_P", 64'(p_out[7]), 64'(frozen_p));
                    check_value("stall_VALID", 64'(v_out[7]), 64'(frozen_v));
                end
                CEN = 1'b1;
            end
            tick();
        end
        apply(18'h0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        // Asynchronous reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            apply(18'(100 + i), 18'd3, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        #2 RESET = 1'b1;
        #1 check_value("async_rst_P", 64'(p_out[7]), 64'd0);
        check_value("async_rst_VALID", 64'(v_out[7]), 64'd0);
        compare_all();
        #1 RESET = 1'b0;
        apply(18'd9, 18'd9, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        apply(18'h0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_value("post_rst_no_stale", 64'(v_out[7]), 64'd0);
        tick();
        check_value("post_rst_P", 64'(p_out[7]), 64'd81);
        check_value("post_rst_VALID", 64'(v_out[7]), 64'd1);

        // Random sweep across all configurations
        for (int i = 0; i < 400; i++) begin
            apply(18'($urandom), 18'($urandom), 18'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            CEN = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #2 RESET = 1'b1;
                #1 compare_all();
                #1 RESET = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
